// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus/check engine for a combinational gate: sweeps every input
// vector, holds it for SETTLE+1 cycles, and compares the sampled output to TRUTH.
module gate_sweep_checker #(
  parameter int unsigned            N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b1000,
  parameter int unsigned            SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int unsigned     N_VEC      = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(N_VEC - 1);
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } state_t;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [3:0]      hold_cnt;

  logic            window_end;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // The DUT is driven straight from the registered vector, so stim only moves on
  // window-boundary edges and the compare never depends on combinational feedback.
  assign stim = vec;

  always_comb begin
    window_end = 1'b0;
    mismatch   = 1'b0;
    err_next   = err_count;
    if (state == HOLD && hold_cnt == SETTLE_CNT) begin
      window_end = 1'b1;
      // Case inequality so an X/Z output from the gate is reported as a failure.
      mismatch   = (dut_out !== TRUTH[vec]);
      err_next   = err_count + (N_IN + 1)'(mismatch);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      hold_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= HOLD;
            vec            <= '0;
            hold_cnt       <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        HOLD: begin
          if (window_end) begin
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_vec <= vec;
            end
            if (vec != LAST_VEC) begin
              vec      <= vec + N_IN'(1);
              hold_cnt <= '0;
            end else begin
              // Final sample is folded into pass on the same edge that raises done.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: two checker instances (2-input/SETTLE=1 and 3-input/SETTLE=0)
// against a sweep-level reference model plus directed literal expectations.
module tb_gate_sweep_checker;

  localparam logic [3:0] TRUTH_A = 4'b1000;
  localparam logic [7:0] TRUTH_B = 8'b1000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] gate_a = 4'b1000;
  logic [7:0] gate_b = 8'b1000_0000;

  logic [1:0] stim_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [2:0] err_a;
  logic [1:0] ff_a;
  logic       dut_out_a;

  logic [2:0] stim_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [3:0] err_b;
  logic [2:0] ff_b;
  logic       dut_out_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural gates under test: truth tables indexed by the driven vector.
  assign dut_out_a = gate_a[stim_a];
  assign dut_out_b = gate_b[stim_b];

  gate_sweep_checker #(.N_IN(2), .TRUTH(TRUTH_A), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .first_fail_vec(ff_a)
  );

  gate_sweep_checker #(.N_IN(3), .TRUTH(TRUTH_B), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .first_fail_vec(ff_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Sweep-level model: k edges since start was accepted; a window of s+1 cycles per vector.
  bit ma_run, ma_dn, mb_run, mb_dn;
  int ma_k, mb_k;
  logic [7:0] ma_tt, mb_tt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_run = 0; ma_dn = 0; ma_k = 0; ma_tt = '0;
    end else if (!ma_run && start_a) begin
      ma_run = 1; ma_dn = 0; ma_k = 0; ma_tt = {4'b0, gate_a};
    end else if (ma_run) begin
      ma_k++;
      if (ma_k == 4 * 2) begin ma_run = 0; ma_dn = 1; end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_run = 0; mb_dn = 0; mb_k = 0; mb_tt = '0;
    end else if (!mb_run && start_b) begin
      mb_run = 1; mb_dn = 0; mb_k = 0; mb_tt = gate_b;
    end else if (mb_run) begin
      mb_k++;
      if (mb_k == 8 * 1) begin mb_run = 0; mb_dn = 1; end
    end
  end

  task automatic model_exp(input int n, input int s, input logic [7:0] truth,
                           input logic [7:0] tt, input bit run, input bit dn, input int k,
                           output int e_stim, output int e_busy, output int e_done,
                           output int e_pass, output int e_err, output int e_fv,
                           output int e_ff);
    int nv, comp;
    nv = 1 << n;
    e_stim = 0; e_busy = 0; e_done = 0; e_pass = 0; e_err = 0; e_fv = 0; e_ff = 0;
    if (run || dn) begin
      comp   = dn ? nv : k / (s + 1);
      e_stim = dn ? nv - 1 : k / (s + 1);
      e_busy = run ? 1 : 0;
      e_done = dn ? 1 : 0;
      for (int i = 0; i < comp; i++) begin
        if (tt[i] != truth[i]) begin
          e_err++;
          if (e_fv == 0) begin e_fv = 1; e_ff = i; end
        end
      end
      e_pass = (dn && e_err == 0) ? 1 : 0;
    end
  endtask

  always @(negedge clk) begin
    int es, eb, ed, ep, ee, ef, eff;
    model_exp(2, 1, {4'b0, TRUTH_A}, ma_tt, ma_run, ma_dn, ma_k, es, eb, ed, ep, ee, ef, eff);
    chk("a_stim", 32'(stim_a), es);      chk("a_busy", 32'(busy_a), eb);
    chk("a_done", 32'(done_a), ed);      chk("a_pass", 32'(pass_a), ep);
    chk("a_err_count", 32'(err_a), ee);  chk("a_fail_valid", 32'(fv_a), ef);
    chk("a_first_fail", 32'(ff_a), eff);
    model_exp(3, 0, TRUTH_B, mb_tt, mb_run, mb_dn, mb_k, es, eb, ed, ep, ee, ef, eff);
    chk("b_stim", 32'(stim_b), es);      chk("b_busy", 32'(busy_b), eb);
    chk("b_done", 32'(done_b), ed);      chk("b_pass", 32'(pass_b), ep);
    chk("b_err_count", 32'(err_b), ee);  chk("b_fail_valid", 32'(fv_b), ef);
    chk("b_first_fail", 32'(ff_b), eff);
  end

  // Pulses start_a, optionally re-pulses it at edge rep or resets at edge rst_at;
  // lat is the number of edges from acceptance to done (-1 when aborted).
  task automatic run_a(input int rep, input int rst_at, output int lat, output int seq[8]);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    start_a = 1'b0;
    while (!done_a && lat < 50) begin
      if (lat < 8) seq[lat] = int'(stim_a);
      start_a = (lat == rep);
      if (lat == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_immediate", {stim_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        lat = -1;
        return;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_a = 1'b0;
  endtask

  task automatic run_b(output int lat);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    chk("b_err_cleared_on_start", 32'(err_b), 0);
    lat = 0;
    while (!done_b && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seq[8];
    int exp_seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_a", {stim_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a}, 0);
    rst_n = 1'b1;

    // AND gate, default table.
    gate_a = 4'b1000;
    run_a(-1, -1, lat, seq);
    chk("and_latency", lat, 8);
    for (int i = 0; i < 8; i++) chk("and_stim_seq", seq[i], exp_seq[i]);
    chk("and_err", 32'(err_a), 0);
    chk("and_pass", 32'(pass_a), 1);
    chk("and_fail_valid", 32'(fv_a), 0);

    // Stuck-at-0 output.
    gate_a = 4'b0000;
    run_a(-1, -1, lat, seq);
    chk("sa0_err", 32'(err_a), 1);
    chk("sa0_fail_valid", 32'(fv_a), 1);
    chk("sa0_first_fail", 32'(ff_a), 3);
    chk("sa0_pass", 32'(pass_a), 0);

    // OR gate against the AND table.
    gate_a = 4'b1110;
    run_a(-1, -1, lat, seq);
    chk("or_err", 32'(err_a), 2);
    chk("or_first_fail", 32'(ff_a), 1);
    chk("or_pass", 32'(pass_a), 0);

    // Start re-pulsed while vector 01 is driven: ignored.
    run_a(2, -1, lat, seq);
    chk("repulse_latency", lat, 8);
    chk("repulse_err", 32'(err_a), 2);
    chk("repulse_first_fail", 32'(ff_a), 1);

    // Reset during vector 10, then a fresh sweep with a stuck-at-0 gate.
    run_a(-1, 4, lat, seq);
    chk("after_reset_idle", {busy_a, done_a, err_a}, 0);
    gate_a = 4'b0000;
    run_a(-1, -1, lat, seq);
    chk("post_reset_latency", lat, 8);
    chk("post_reset_stim_start", seq[0], 0);
    chk("post_reset_err", 32'(err_a), 1);

    // 3-input instance: broken gate, then restart from DONE with a correct AND.
    gate_b = 8'b0000_0000;
    run_b(lat);
    chk("b_broken_err", 32'(err_b), 1);
    chk("b_broken_first_fail", 32'(ff_b), 7);
    gate_b = 8'b1000_0000;
    run_b(lat);
    chk("b_latency", lat, 8);
    chk("b_pass", 32'(pass_b), 1);
    chk("b_err", 32'(err_b), 0);

    // Randomized traffic: random gates, start pulses (incl. held high) and resets.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (!busy_a && $urandom_range(0, 3) == 0) gate_a = 4'($urandom);
      if (!busy_b && $urandom_range(0, 3) == 0) gate_b = 8'($urandom);
      start_a = ($urandom_range(0, 5) == 0) || (c >= 700 && c < 760);
      start_b = ($urandom_range(0, 5) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; rst_n = 1'b1;
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
